// File: rtl/timer_irq_gen.sv
// Memory-mapped interval timer with reload, prescaler, free-running SYSTICK
// and a level interrupt that holds until software clears it through TCON.
module timer_irq_gen #(
  parameter logic [31:0] BASE_ADDR = 32'h40000000,
  parameter int unsigned PRESCALE  = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic        MemRd,
  input  logic        MemWr,
  output logic [31:0] rdata,
  output logic        irqout
);

  // Word offsets inside the 32-byte register window
  localparam logic [2:0] OFF_TH      = 3'd0;
  localparam logic [2:0] OFF_TL      = 3'd1;
  localparam logic [2:0] OFF_TCON    = 3'd2;
  localparam logic [2:0] OFF_SYSTICK = 3'd5;

  localparam logic [31:0] PRE_MAX = PRESCALE - 1;
  localparam logic [31:0] TL_MAX  = 32'hFFFF_FFFF;

  logic [31:0] th;
  logic [31:0] tl;
  logic        en;
  logic        ie;
  logic        st;
  logic [31:0] systick;
  logic [31:0] pre;

  logic        sel;
  logic [2:0]  off;
  logic        wr_th;
  logic        wr_tl;
  logic        wr_tcon;
  logic        tick;
  logic        ovf;

  // Byte-lane bits are ignored; they are folded here only so they are not dangling
  logic        unused_addr_lsb;
  assign unused_addr_lsb = ^addr[1:0];

  assign sel     = (addr[31:5] == BASE_ADDR[31:5]);
  assign off     = addr[4:2];
  assign wr_th   = MemWr & sel & (off == OFF_TH);
  assign wr_tl   = MemWr & sel & (off == OFF_TL);
  assign wr_tcon = MemWr & sel & (off == OFF_TCON);

  // A tick fires on the last prescaler phase while counting is enabled
  assign tick = en & (pre == PRE_MAX);

  // A software TL write on the same edge suppresses the overflow entirely
  assign ovf  = tick & (tl == TL_MAX) & ~wr_tl;

  // Prescaler: runs 0..PRESCALE-1 while enabled, parked at 0 otherwise
  always_ff @(posedge clk) begin
    if (reset) begin
      pre <= '0;
    end else if (wr_tcon && !wdata[0]) begin
      pre <= '0;
    end else if (!en) begin
      pre <= '0;
    end else if (tick) begin
      pre <= '0;
    end else begin
      pre <= pre + 32'd1;
    end
  end

  // Reload register: plain software-owned storage
  always_ff @(posedge clk) begin
    if (reset) begin
      th <= '0;
    end else if (wr_th) begin
      th <= wdata;
    end
  end

  // Counter: software write beats the tick; overflow reloads the pre-edge TH
  always_ff @(posedge clk) begin
    if (reset) begin
      tl <= '0;
    end else if (wr_tl) begin
      tl <= wdata;
    end else if (tick) begin
      if (tl == TL_MAX) begin
        tl <= th;
      end else begin
        tl <= tl + 32'd1;
      end
    end
  end

  // Control/status: an overflow with IE set always lands in ST, even across a TCON write
  always_ff @(posedge clk) begin
    if (reset) begin
      en <= 1'b0;
      ie <= 1'b0;
      st <= 1'b0;
    end else if (wr_tcon) begin
      en <= wdata[0];
      ie <= wdata[1];
      st <= wdata[2] | (ovf & ie);
    end else if (ovf && ie) begin
      st <= 1'b1;
    end
  end

  // Free-running cycle counter, read-only from the bus
  always_ff @(posedge clk) begin
    if (reset) begin
      systick <= '0;
    end else begin
      systick <= systick + 32'd1;
    end
  end

  // Load path: combinational view of the pre-edge register contents
  always_comb begin
    rdata = '0;
    if (MemRd && sel) begin
      case (off)
        OFF_TH:      rdata = th;
        OFF_TL:      rdata = tl;
        OFF_TCON:    rdata = {29'd0, st, ie, en};
        OFF_SYSTICK: rdata = systick;
        default:     rdata = '0;
      endcase
    end
  end

  assign irqout = ie & st;

endmodule

// File: tb/tb_timer_irq_gen.sv
// Bench for timer_irq_gen: two instances (PRESCALE=1 and PRESCALE=4) share one
// bus; a behavioural model predicts every cycle, directed steps pin literals.
module tb_timer_irq_gen;

  localparam logic [31:0] BASE = 32'h40000000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] addr = '0;
  logic [31:0] wdata = '0;
  logic        MemRd = 1'b0;
  logic        MemWr = 1'b0;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  int vectors = 0;
  int miscompares = 0;
  bit chk_on = 1'b1;

  always #5 clk = ~clk;

  timer_irq_gen #(.BASE_ADDR(BASE), .PRESCALE(1)) u_p1 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRd(MemRd), .MemWr(MemWr), .rdata(rd0), .irqout(irq0)
  );

  timer_irq_gen #(.BASE_ADDR(BASE), .PRESCALE(4)) u_p4 (
    .clk(clk), .reset(reset), .addr(addr), .wdata(wdata),
    .MemRd(MemRd), .MemWr(MemWr), .rdata(rd1), .irqout(irq1)
  );

  // Behavioural model state, one slot per instance
  logic [31:0] m_th[2], m_tl[2], m_pre[2];
  bit          m_en[2], m_ie[2], m_st[2];
  logic [31:0] m_sys;

  initial begin
    for (int i = 0; i < 2; i++) begin
      m_th[i] = '0; m_tl[i] = '0; m_pre[i] = '0;
      m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0;
    end
    m_sys = '0;
  end

  function automatic int prescale_of(int i);
    return (i == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] exp_rd(int i);
    if (!MemRd || addr[31:5] != BASE[31:5]) return '0;
    case (addr[4:2])
      3'd0: return m_th[i];
      3'd1: return m_tl[i];
      3'd2: return {29'd0, m_st[i], m_ie[i], m_en[i]};
      3'd5: return m_sys;
      default: return '0;
    endcase
  endfunction

  // Advance the model by one clock edge using the bus as it stands at the edge
  task automatic model_step();
    bit sel, wth, wtl, wtc, tick, wrap;
    int off;
    sel = (addr[31:5] == BASE[31:5]);
    off = int'(addr[4:2]);
    wth = MemWr && sel && off == 0;
    wtl = MemWr && sel && off == 1;
    wtc = MemWr && sel && off == 2;
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        m_th[i] = '0; m_tl[i] = '0; m_pre[i] = '0;
        m_en[i] = 0; m_ie[i] = 0; m_st[i] = 0;
      end
      m_sys = '0;
      return;
    end
    m_sys = m_sys + 1;
    for (int i = 0; i < 2; i++) begin
      logic [31:0] old_th;
      bit old_ie;
      old_th = m_th[i];
      old_ie = m_ie[i];
      tick = m_en[i] && (int'(m_pre[i]) == prescale_of(i) - 1);
      wrap = tick && (m_tl[i] == 32'hFFFFFFFF) && !wtl;
      if (wtc && !wdata[0]) m_pre[i] = '0;
      else if (!m_en[i] || tick) m_pre[i] = '0;
      else m_pre[i] = m_pre[i] + 1;
      if (wtl) m_tl[i] = wdata;
      else if (wrap) m_tl[i] = old_th;
      else if (tick) m_tl[i] = m_tl[i] + 1;
      if (wth) m_th[i] = wdata;
      if (wtc) begin
        m_en[i] = wdata[0];
        m_ie[i] = wdata[1];
        m_st[i] = wdata[2] || (wrap && old_ie);
      end else if (wrap && old_ie) begin
        m_st[i] = 1;
      end
    end
  endtask

  always @(posedge clk) model_step();

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_on) begin
      chk("rdata_p1", rd0, exp_rd(0));
      chk("rdata_p4", rd1, exp_rd(1));
      chk("irq_p1", {31'd0, irq0}, {31'd0, (m_ie[0] & m_st[0])});
      chk("irq_p4", {31'd0, irq1}, {31'd0, (m_ie[1] & m_st[1])});
    end
  end

  task automatic apply(input bit rs, input bit rdv, input bit wrv,
                       input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset = rs; MemRd = rdv; MemWr = wrv; addr = a; wdata = d;
    @(negedge clk);
    #1;
  endtask

  task automatic rd(input logic [31:0] off);
    apply(0, 1, 0, BASE + off, '0);
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] d);
    apply(0, 0, 1, BASE + off, d);
  endtask

  logic [31:0] sa, sb;

  initial begin
    // Reset held: every register reads zero
    apply(1, 1, 0, BASE + 32'h00, '0); chk("rst_th", rd0, 32'h0);
    apply(1, 1, 0, BASE + 32'h04, '0); chk("rst_tl", rd0, 32'h0);
    apply(1, 1, 0, BASE + 32'h08, '0); chk("rst_tcon", rd0, 32'h0);
    apply(1, 1, 0, BASE + 32'h14, '0); chk("rst_sys", rd0, 32'h0);
    chk("rst_irq", {31'd0, irq0}, 32'h0);
    rd(32'h14); chk("sys_1st", rd0, 32'd0);
    rd(32'h14); chk("sys_2nd", rd0, 32'd1);
    rd(32'h14); chk("sys_3rd", rd0, 32'd2);

    // Overflow and reload with PRESCALE=1
    wr(32'h00, 32'hFFFFFFF0);
    wr(32'h04, 32'hFFFFFFFE);
    wr(32'h08, 32'h3);
    rd(32'h04); chk("tl_fe", rd0, 32'hFFFFFFFE); chk("irq_pre", {31'd0, irq0}, 32'h0);
    rd(32'h04); chk("tl_ff", rd0, 32'hFFFFFFFF);
    rd(32'h04); chk("tl_reload", rd0, 32'hFFFFFFF0); chk("irq_rise", {31'd0, irq0}, 32'h1);
    rd(32'h04); chk("tl_f1", rd0, 32'hFFFFFFF1); chk("irq_hold", {31'd0, irq0}, 32'h1);

    // Clear ST by rewriting TCON; counting continues
    wr(32'h08, 32'h3);
    rd(32'h08); chk("tcon_clr", rd0, 32'h3); chk("irq_clr", {31'd0, irq0}, 32'h0);
    rd(32'h04); chk("tl_f4", rd0, 32'hFFFFFFF4);

    // TCON write landing on the overflow edge keeps the interrupt
    wr(32'h04, 32'hFFFFFFFF);
    wr(32'h08, 32'h3);
    rd(32'h08); chk("tcon_coll", rd0, 32'h7); chk("irq_coll", {31'd0, irq0}, 32'h1);
    rd(32'h04); chk("tl_coll", rd0, 32'hFFFFFFF1);

    // PRESCALE=4 cadence, then a pause via EN=0
    wr(32'h08, 32'h0);
    wr(32'h04, 32'h0);
    wr(32'h08, 32'h1);
    for (int k = 1; k <= 9; k++) begin
      rd(32'h04);
      if (k == 4) chk("p4_tl_0", rd1, 32'd0);
      if (k == 5) chk("p4_tl_1", rd1, 32'd1);
      if (k == 8) chk("p4_tl_1b", rd1, 32'd1);
      if (k == 9) chk("p4_tl_2", rd1, 32'd2);
    end
    wr(32'h08, 32'h0);
    wr(32'h08, 32'h0);
    wr(32'h08, 32'h1);
    for (int k = 1; k <= 5; k++) begin
      rd(32'h04);
      if (k == 4) chk("p4_resume_2", rd1, 32'd2);
      if (k == 5) chk("p4_resume_3", rd1, 32'd3);
    end

    // Writes to read-only, unmapped and out-of-window addresses
    rd(32'h14); sa = rd0;
    wr(32'h14, 32'h0);
    wr(32'h0C, 32'h5);
    rd(32'h0C); chk("hole_0c", rd0, 32'h0);
    rd(32'h14); sb = rd0;
    chk("sys_delta", sb - sa, 32'd4);
    rd(32'h00); chk("th_before", rd0, 32'hFFFFFFF0);
    wr(32'h20, 32'h12345678);
    rd(32'h00); chk("th_after", rd0, 32'hFFFFFFF0);
    rd(32'h20); chk("outside_rd", rd0, 32'h0);

    // Randomized traffic, checked by the model every cycle
    for (int n = 0; n < 3000; n++) begin
      int r, o;
      logic [31:0] a, d;
      bit rs, rdv, wrv;
      r = $urandom_range(0, 99);
      rs = (r < 2);
      rdv = ($urandom_range(0, 9) < 6);
      wrv = ($urandom_range(0, 9) < 3);
      case ($urandom_range(0, 9))
        0, 1:    o = 0;
        2, 3, 4: o = 1;
        5, 6:    o = 2;
        7:       o = 5;
        8:       o = 3;
        default: o = 7;
      endcase
      a = BASE + 32'(o * 4);
      if ($urandom_range(0, 19) == 0) a = BASE + 32'h20 + 32'(o * 4);
      d = $urandom;
      if (o == 1 && $urandom_range(0, 1) == 0) d = 32'hFFFFFFFF - 32'($urandom_range(0, 8));
      if (o == 0 && $urandom_range(0, 1) == 0) d = 32'hFFFFFFF0 + 32'($urandom_range(0, 15));
      if (o == 2) d = 32'($urandom_range(0, 7));
      apply(rs, rdv, wrv, a, d);
    end

    apply(0, 0, 0, '0, '0);
    chk_on = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
